// File: rtl/pa_idu_gpr_pkg.sv
// Shared constants for the IDU GPR read side: per-register busy encodings,
// reader FSM states and the GPR data width.
package pa_idu_gpr_pkg;

  localparam int unsigned GPR_DW = 32;

  localparam logic [2:0] IDLE      = 3'b000;
  localparam logic [2:0] BUSY1     = 3'b001;
  localparam logic [2:0] BUSY_LSU1 = 3'b010;
  localparam logic [2:0] BUSY_DIV1 = 3'b011;
  localparam logic [2:0] BUSY2     = 3'b100;
  localparam logic [2:0] BUSY_LSU2 = 3'b110;
  localparam logic [2:0] BUSY_DIV2 = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_VLD  = 2'd2;

endpackage

// File: rtl/pa_idu_gpr_src_sel.sv
// Combinational source selector: picks one register's busy state, forward strobes
// and bypassed data, and decides whether the operand can be taken this cycle.
module pa_idu_gpr_src_sel
  import pa_idu_gpr_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned IDXW = 5
) (
  input  logic [IDXW-1:0]        idx_i,
  input  logic                   en_i,
  input  logic [NREG*3-1:0]      busy_flat_i,
  input  logic [NREG*GPR_DW-1:0] dout_flat_i,
  input  logic [NREG-1:0]        fwd_en0_i,
  input  logic [NREG-1:0]        fwd_en1_i,
  input  logic [NREG-1:0]        fwd_en2_i,
  output logic                   src_ready_o,
  output logic [GPR_DW-1:0]      src_data_o
);

  logic [2:0]        busy;
  logic [GPR_DW-1:0] dout;
  logic              f0, f1, f2;
  logic              hit;
  logic              zero_src;
  logic              busy_ready;

  always_comb begin
    busy = IDLE;
    dout = '0;
    f0   = 1'b0;
    f1   = 1'b0;
    f2   = 1'b0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx_i == IDXW'(i)) begin
        busy = busy_flat_i[i*3 +: 3];
        dout = dout_flat_i[i*GPR_DW +: GPR_DW];
        f0   = fwd_en0_i[i];
        f1   = fwd_en1_i[i];
        f2   = fwd_en2_i[i];
        hit  = 1'b1;
      end
    end
  end

  // Indices beyond NREG (RV32E) behave like x0 so the reader never deadlocks.
  assign zero_src = !en_i || (idx_i == '0) || !hit;

  always_comb begin
    case (busy)
      IDLE:      busy_ready = 1'b1;
      BUSY1:     busy_ready = f0 | f1 | f2;
      BUSY_LSU1: busy_ready = f1 | f2;
      BUSY_DIV1: busy_ready = f0 | f2;
      default:   busy_ready = 1'b0;
    endcase
  end

  assign src_ready_o = zero_src | busy_ready;
  assign src_data_o  = zero_src ? '0 : dout;

endmodule

// File: rtl/pa_idu_gpr_rd.sv
// IDU GPR read side: holds one decoded instruction until both sources are
// hazard-free, then hands the operands to EX1. Optional PA_IDU_GPR_RD_STALL_CNT_EN.
module pa_idu_gpr_rd
  import pa_idu_gpr_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned IDXW = 5
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  input  logic                   rtu_idu_flush_fe,
  input  logic                   id_rd_vld,
  output logic                   id_rd_rdy,
  input  logic                   id_rs1_en,
  input  logic                   id_rs2_en,
  input  logic [IDXW-1:0]        id_rs1_idx,
  input  logic [IDXW-1:0]        id_rs2_idx,
  input  logic [NREG*3-1:0]      gpr_busy_st_flat,
  input  logic [NREG*GPR_DW-1:0] gpr_dout_flat,
  input  logic [NREG-1:0]        fwd_en0_x,
  input  logic [NREG-1:0]        fwd_en1_x,
  input  logic [NREG-1:0]        fwd_en2_x,
  output logic                   ex_opnd_vld,
  input  logic                   ex_opnd_rdy,
  output logic [GPR_DW-1:0]      ex_rs1_data,
  output logic [GPR_DW-1:0]      ex_rs2_data,
  output logic                   idu_rd_stall
`ifdef PA_IDU_GPR_RD_STALL_CNT_EN
  ,
  output logic [31:0]            idu_rd_stall_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic              rs1_cap_q, rs1_cap_d, rs2_cap_q, rs2_cap_d;
  logic              rs1_en_q, rs1_en_d, rs2_en_q, rs2_en_d;
  logic [IDXW-1:0]   rs1_idx_q, rs1_idx_d, rs2_idx_q, rs2_idx_d;
  logic [GPR_DW-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;

  logic              accept;
  logic              sel1_en, sel2_en;
  logic [IDXW-1:0]   sel1_idx, sel2_idx;
  logic              rs1_ready, rs2_ready;
  logic [GPR_DW-1:0] rs1_sel_data, rs2_sel_data;

  assign id_rd_rdy = (state_q == S_IDLE) || ((state_q == S_VLD) && ex_opnd_rdy);
  assign accept    = id_rd_vld && id_rd_rdy && !rtu_idu_flush_fe;

  // Selectors look at the incoming instruction on accept, otherwise at the held one.
  assign sel1_en  = accept ? id_rs1_en  : rs1_en_q;
  assign sel2_en  = accept ? id_rs2_en  : rs2_en_q;
  assign sel1_idx = accept ? id_rs1_idx : rs1_idx_q;
  assign sel2_idx = accept ? id_rs2_idx : rs2_idx_q;

  pa_idu_gpr_src_sel #(
    .NREG (NREG),
    .IDXW (IDXW)
  ) u_src1_sel (
    .idx_i       (sel1_idx),
    .en_i        (sel1_en),
    .busy_flat_i (gpr_busy_st_flat),
    .dout_flat_i (gpr_dout_flat),
    .fwd_en0_i   (fwd_en0_x),
    .fwd_en1_i   (fwd_en1_x),
    .fwd_en2_i   (fwd_en2_x),
    .src_ready_o (rs1_ready),
    .src_data_o  (rs1_sel_data)
  );

  pa_idu_gpr_src_sel #(
    .NREG (NREG),
    .IDXW (IDXW)
  ) u_src2_sel (
    .idx_i       (sel2_idx),
    .en_i        (sel2_en),
    .busy_flat_i (gpr_busy_st_flat),
    .dout_flat_i (gpr_dout_flat),
    .fwd_en0_i   (fwd_en0_x),
    .fwd_en1_i   (fwd_en1_x),
    .fwd_en2_i   (fwd_en2_x),
    .src_ready_o (rs2_ready),
    .src_data_o  (rs2_sel_data)
  );

  always_comb begin
    state_d    = state_q;
    rs1_cap_d  = rs1_cap_q;
    rs2_cap_d  = rs2_cap_q;
    rs1_en_d   = rs1_en_q;
    rs2_en_d   = rs2_en_q;
    rs1_idx_d  = rs1_idx_q;
    rs2_idx_d  = rs2_idx_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;

    if (rtu_idu_flush_fe) begin
      state_d   = S_IDLE;
      rs1_cap_d = 1'b0;
      rs2_cap_d = 1'b0;
    end else if (accept) begin
      rs1_en_d  = id_rs1_en;
      rs2_en_d  = id_rs2_en;
      rs1_idx_d = id_rs1_idx;
      rs2_idx_d = id_rs2_idx;
      rs1_cap_d = rs1_ready;
      rs2_cap_d = rs2_ready;
      if (rs1_ready) rs1_data_d = rs1_sel_data;
      if (rs2_ready) rs2_data_d = rs2_sel_data;
      state_d = (rs1_ready && rs2_ready) ? S_VLD : S_WAIT;
    end else begin
      case (state_q)
        S_WAIT: begin
          // Captured operands are frozen; only pending ones may still load.
          if (!rs1_cap_q && rs1_ready) begin
            rs1_cap_d  = 1'b1;
            rs1_data_d = rs1_sel_data;
          end
          if (!rs2_cap_q && rs2_ready) begin
            rs2_cap_d  = 1'b1;
            rs2_data_d = rs2_sel_data;
          end
          if (rs1_cap_d && rs2_cap_d) state_d = S_VLD;
        end
        S_VLD: begin
          if (ex_opnd_rdy) begin
            state_d   = S_IDLE;
            rs1_cap_d = 1'b0;
            rs2_cap_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q    <= S_IDLE;
      rs1_cap_q  <= 1'b0;
      rs2_cap_q  <= 1'b0;
      rs1_en_q   <= 1'b0;
      rs2_en_q   <= 1'b0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rs1_cap_q  <= rs1_cap_d;
      rs2_cap_q  <= rs2_cap_d;
      rs1_en_q   <= rs1_en_d;
      rs2_en_q   <= rs2_en_d;
      rs1_idx_q  <= rs1_idx_d;
      rs2_idx_q  <= rs2_idx_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign ex_opnd_vld  = (state_q == S_VLD);
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign idu_rd_stall = (state_q == S_WAIT);

`ifdef PA_IDU_GPR_RD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating; survives flush so it measures total hazard time since reset.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      stall_cnt_q <= '0;
    end else if (idu_rd_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign idu_rd_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pa_idu_gpr_rd.sv
// Self-checking bench for pa_idu_gpr_rd: operand scoreboard plus direct handshake,
// stall, flush and reset checks.
module tb_pa_idu_gpr_rd;
  import pa_idu_gpr_pkg::*;

  logic          clk;
  logic          cpurst;
  logic          flush;
  logic          id_rd_vld;
  logic          id_rd_rdy;
  logic          rs1_en, rs2_en;
  logic [4:0]    rs1_idx, rs2_idx;
  logic [95:0]   busy_flat;
  logic [1023:0] dout_flat;
  logic [31:0]   fwd0, fwd1, fwd2;
  logic          ex_vld;
  logic          ex_rdy;
  logic [31:0]   ex_rs1, ex_rs2;
  logic          stall;
  logic [31:0]   stall_cnt;

  logic [2:0]    busy [32];
  logic [31:0]   dout [32];
  logic [63:0]   sb [$];

  int            n_checks;
  int            n_fail;
  logic          exp_wait;
  logic [31:0]   exp_cnt;

  pa_idu_gpr_rd #(
    .NREG (32),
    .IDXW (5)
  ) dut (
    .forever_cpuclk   (clk),
    .cpurst           (cpurst),
    .rtu_idu_flush_fe (flush),
    .id_rd_vld        (id_rd_vld),
    .id_rd_rdy        (id_rd_rdy),
    .id_rs1_en        (rs1_en),
    .id_rs2_en        (rs2_en),
    .id_rs1_idx       (rs1_idx),
    .id_rs2_idx       (rs2_idx),
    .gpr_busy_st_flat (busy_flat),
    .gpr_dout_flat    (dout_flat),
    .fwd_en0_x        (fwd0),
    .fwd_en1_x        (fwd1),
    .fwd_en2_x        (fwd2),
    .ex_opnd_vld      (ex_vld),
    .ex_opnd_rdy      (ex_rdy),
    .ex_rs1_data      (ex_rs1),
    .ex_rs2_data      (ex_rs2),
    .idu_rd_stall     (stall)
`ifdef PA_IDU_GPR_RD_STALL_CNT_EN
    ,
    .idu_rd_stall_cnt (stall_cnt)
`endif
  );

`ifndef PA_IDU_GPR_RD_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      busy_flat[i*3 +: 3]   = busy[i];
      dout_flat[i*32 +: 32] = dout[i];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (exp_wait && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic e1, input logic [4:0] i1, input logic e2,
                       input logic [4:0] i2);
    id_rd_vld = 1'b1;
    rs1_en    = e1;
    rs1_idx   = i1;
    rs2_en    = e2;
    rs2_idx   = i2;
    #1;
    check_eq("id_rdy", 64'(id_rd_rdy), 64'd1);
    tick();
    id_rd_vld = 1'b0;
  endtask

  task automatic consume();
    ex_rdy = 1'b1;
    tick();
    ex_rdy = 1'b0;
    check_eq("vld_drop", 64'(ex_vld), 64'd0);
  endtask

  // Scoreboard: each handshake with EX1 retires the oldest expected operand pair.
  always @(negedge clk) begin : sb_mon
    logic [63:0] e;
    if (!cpurst && ex_vld && ex_rdy) begin
      check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("sb_opnd", {ex_rs1, ex_rs2}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_wait  = 1'b0;
    exp_cnt   = '0;
    cpurst    = 1'b1;
    flush     = 1'b0;
    id_rd_vld = 1'b0;
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    rs1_idx   = '0;
    rs2_idx   = '0;
    fwd0      = '0;
    fwd1      = '0;
    fwd2      = '0;
    ex_rdy    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      busy[i] = IDLE;
      dout[i] = 32'h0101_0101 * i;
    end
    // x0 field carries garbage that must be ignored.
    busy[0] = BUSY2;
    dout[0] = 32'hFFFF_FFFF;
    dout[5] = 32'h0000_1234;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vld", 64'(ex_vld), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_data", {ex_rs1, ex_rs2}, 64'd0);
    check_eq("rst_rdy", 64'(id_rd_rdy), 64'd1);
`ifdef PA_IDU_GPR_RD_STALL_CNT_EN
    check_eq("rst_cnt", 64'(stall_cnt), 64'd0);
`endif
    cpurst = 1'b0;
    tick();

    // No hazard: x5 and x0, one-cycle latency.
    sb.push_back({32'h0000_1234, 32'h0});
    issue(1'b1, 5'd5, 1'b1, 5'd0);
    check_eq("nohaz_vld", 64'(ex_vld), 64'd1);
    check_eq("nohaz_stall", 64'(stall), 64'd0);
    dout[5] = 32'h0000_DEAD;
    tick();
    check_eq("hold_rs1", 64'(ex_rs1), 64'h1234);
    check_eq("hold_rdy", 64'(id_rd_rdy), 64'd0);
    consume();

    // LSU hazard on x7, released by the LSU port after 3 stall cycles.
    busy[7] = BUSY_LSU1;
    dout[7] = 32'h0;
    sb.push_back({32'hCAFE_0000, 32'h0});
    issue(1'b1, 5'd7, 1'b0, 5'd7);
    exp_wait = 1'b1;
    check_eq("lsu_stall0", 64'(stall), 64'd1);
    for (int k = 1; k < 3; k++) begin
      tick();
      check_eq("lsu_stall", 64'(stall), 64'd1);
      check_eq("lsu_novld", 64'(ex_vld), 64'd0);
    end
    fwd1[7] = 1'b1;
    dout[7] = 32'hCAFE_0000;
    tick();
    exp_wait = 1'b0;
    fwd1[7]  = 1'b0;
    busy[7]  = IDLE;
    check_eq("lsu_vld", 64'(ex_vld), 64'd1);
    check_eq("lsu_stall_off", 64'(stall), 64'd0);
    consume();

    // DIV hazard on x9: LSU strobe must not release it, ALU strobe does.
    busy[9] = BUSY_DIV1;
    dout[9] = 32'h0000_0BAD;
    sb.push_back({32'h0000_DEAD, 32'h9999_0009});
    issue(1'b1, 5'd5, 1'b1, 5'd9);
    exp_wait = 1'b1;
    fwd1[9]  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("div_wrongport", 64'(stall), 64'd1);
    end
    fwd1[9] = 1'b0;
    fwd0[9] = 1'b1;
    dout[9] = 32'h9999_0009;
    tick();
    exp_wait = 1'b0;
    fwd0[9]  = 1'b0;
    busy[9]  = IDLE;
    check_eq("div_vld", 64'(ex_vld), 64'd1);
    consume();

    // BUSY_LSU2 on x3 ignores the forward; after dropping to LSU1 the DIV port frees it.
    busy[3] = BUSY_LSU2;
    fwd1[3] = 1'b1;
    issue(1'b1, 5'd3, 1'b1, 5'd10);
    exp_wait = 1'b1;
    check_eq("lsu2_stall", 64'(stall), 64'd1);
    tick();
    check_eq("lsu2_hold", 64'(stall), 64'd1);
    busy[3] = BUSY_LSU1;
    fwd1[3] = 1'b0;
    fwd2[3] = 1'b1;
    dout[3] = 32'h3333_3333;
    sb.push_back({32'h3333_3333, 32'h0A0A_0A0A});
    tick();
    exp_wait = 1'b0;
    fwd2[3]  = 1'b0;
    busy[3]  = IDLE;
    check_eq("lsu2_vld", 64'(ex_vld), 64'd1);
    check_eq("lsu2_rs2", 64'(ex_rs2), 64'h0A0A_0A0A);

    // Back-to-back: consume and accept in the same cycle, no bubble.
    ex_rdy = 1'b1;
    sb.push_back({32'h0C0C_0C0C, 32'h0D0D_0D0D});
    issue(1'b1, 5'd12, 1'b1, 5'd13);
    check_eq("b2b_vld", 64'(ex_vld), 64'd1);
    check_eq("b2b_rs1", 64'(ex_rs1), 64'h0C0C_0C0C);
    tick();
    ex_rdy = 1'b0;
    check_eq("b2b_drain", 64'(ex_vld), 64'd0);

    // Flush while waiting; the counter keeps its value across the flush.
    busy[7] = BUSY_LSU1;
    issue(1'b1, 5'd7, 1'b1, 5'd0);
    exp_wait = 1'b1;
    check_eq("fl_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    exp_wait = 1'b0;
    check_eq("fl_stall", 64'(stall), 64'd0);
    check_eq("fl_vld", 64'(ex_vld), 64'd0);
    check_eq("fl_rdy", 64'(id_rd_rdy), 64'd1);
`ifdef PA_IDU_GPR_RD_STALL_CNT_EN
    check_eq("fl_cnt", 64'(stall_cnt), 64'(exp_cnt));
`endif
    busy[7] = IDLE;
    fwd1[7] = 1'b1;
    tick();
    fwd1[7] = 1'b0;
    check_eq("fl_no_ghost", 64'(ex_vld), 64'd0);

    // Accept coinciding with flush is dropped.
    flush = 1'b1;
    issue(1'b1, 5'd12, 1'b1, 5'd13);
    flush = 1'b0;
    check_eq("fl_acc_vld", 64'(ex_vld), 64'd0);
    check_eq("fl_acc_stall", 64'(stall), 64'd0);

    // Asynchronous reset while holding valid operands.
    issue(1'b1, 5'd12, 1'b1, 5'd13);
    check_eq("rst2_pre_vld", 64'(ex_vld), 64'd1);
    #2;
    cpurst = 1'b1;
    #1;
    exp_cnt = '0;
    check_eq("rst2_vld", 64'(ex_vld), 64'd0);
    check_eq("rst2_data", {ex_rs1, ex_rs2}, 64'd0);
    check_eq("rst2_stall", 64'(stall), 64'd0);
`ifdef PA_IDU_GPR_RD_STALL_CNT_EN
    check_eq("rst2_cnt", 64'(stall_cnt), 64'(exp_cnt));
`endif
    #1;
    cpurst = 1'b0;
    tick();
    check_eq("rst2_idle_rdy", 64'(id_rd_rdy), 64'd1);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
